// File: rtl/pu_fifo_sched.sv
// pu_fifo_sched: shares a single FIFO processing unit between N_REQ writers
// and N_REQ readers. At most one FIFO operation is issued per cycle. Writers
// and readers are each chosen round-robin, and write/read ties alternate.
// Occupancy is tracked locally so the FIFO never overflows or underflows.
// A flush request drains the FIFO and then pulses flush_done.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   wr_req/wr_data/wr_attr      writer requests and per-writer payload slices
//   wr_grant                    one-hot, push of that writer happens this cycle
//   rd_req/rd_grant             reader requests, one-hot pop grant
//   rd_data/rd_attr             FIFO head while a read is granted, else 0
//   flush/flush_done            drain request, one-cycle completion pulse
//   count/full/empty            occupancy status
//   fifo_*                      connection to the FIFO instance
//
// state | meaning
// RUN   | arbitrate requests, issue at most one push or pop per cycle
// FLUSH | ignore requests, pop until empty, then pulse flush_done
module pu_fifo_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int ATTR_WIDTH = 4,
  parameter int FIFO_SIZE  = 3,
  parameter int N_REQ      = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_REQ-1:0]                 wr_req,
  input  logic [N_REQ*DATA_WIDTH-1:0]      wr_data,
  input  logic [N_REQ*ATTR_WIDTH-1:0]      wr_attr,
  output logic [N_REQ-1:0]                 wr_grant,
  input  logic [N_REQ-1:0]                 rd_req,
  output logic [N_REQ-1:0]                 rd_grant,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic [ATTR_WIDTH-1:0]            rd_attr,
  input  logic                             flush,
  output logic                             flush_done,
  output logic [$clog2(FIFO_SIZE+1)-1:0]   count,
  output logic                             full,
  output logic                             empty,
  output logic [DATA_WIDTH-1:0]            fifo_data_in,
  output logic [ATTR_WIDTH-1:0]            fifo_attr_in,
  output logic                             fifo_signal_wr,
  output logic                             fifo_signal_oe,
  input  logic [DATA_WIDTH-1:0]            fifo_data_out,
  input  logic [ATTR_WIDTH-1:0]            fifo_attr_out
);

  localparam int CW = $clog2(FIFO_SIZE + 1);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FIFO_SIZE);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count_q, count_nxt;
  logic [PW-1:0] wr_ptr, wr_ptr_nxt, rd_ptr, rd_ptr_nxt;
  logic [PW-1:0] wr_win, rd_win;
  logic          last_wr, last_wr_nxt;
  logic          wr_elig, rd_elig, do_wr, do_rd;

  // First active request at or above ptr, otherwise first active below it.
  function automatic logic [PW-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                            input logic [PW-1:0]    ptr);
    logic          found;
    logic [PW-1:0] win;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req[k] && (k >= int'(ptr))) begin
        found = 1'b1;
        win   = PW'(k);
      end
    end
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req[k]) begin
        found = 1'b1;
        win   = PW'(k);
      end
    end
    return win;
  endfunction

  function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] win);
    return (win == PW'(N_REQ - 1)) ? '0 : win + PW'(1);
  endfunction

  assign wr_win = rr_pick(wr_req, wr_ptr);
  assign rd_win = rr_pick(rd_req, rd_ptr);
  assign count  = count_q;
  assign full   = (count_q == CNT_MAX);
  assign empty  = (count_q == '0);

  always_comb begin
    state_nxt      = state;
    count_nxt      = count_q;
    wr_ptr_nxt     = wr_ptr;
    rd_ptr_nxt     = rd_ptr;
    last_wr_nxt    = last_wr;
    wr_grant       = '0;
    rd_grant       = '0;
    fifo_signal_wr = 1'b0;
    fifo_signal_oe = 1'b0;
    fifo_data_in   = '0;
    fifo_attr_in   = '0;
    rd_data        = '0;
    rd_attr        = '0;
    flush_done     = 1'b0;
    wr_elig        = (|wr_req) && (count_q != CNT_MAX);
    rd_elig        = (|rd_req) && (count_q != '0);
    do_wr          = 1'b0;
    do_rd          = 1'b0;
    case (state)
      RUN: begin
        // On a tie, take the opposite of the previous operation.
        do_wr = wr_elig && (!rd_elig || !last_wr);
        do_rd = rd_elig && !do_wr;
        if (do_wr) begin
          wr_grant[wr_win] = 1'b1;
          fifo_signal_wr   = 1'b1;
          fifo_data_in     = wr_data[int'(wr_win)*DATA_WIDTH +: DATA_WIDTH];
          fifo_attr_in     = wr_attr[int'(wr_win)*ATTR_WIDTH +: ATTR_WIDTH];
          count_nxt        = count_q + CW'(1);
          wr_ptr_nxt       = rr_next(wr_win);
          last_wr_nxt      = 1'b1;
        end else if (do_rd) begin
          rd_grant[rd_win] = 1'b1;
          fifo_signal_oe   = 1'b1;
          rd_data          = fifo_data_out;
          rd_attr          = fifo_attr_out;
          count_nxt        = count_q - CW'(1);
          rd_ptr_nxt       = rr_next(rd_win);
          last_wr_nxt      = 1'b0;
        end
        if (flush) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (count_q != '0) begin
          fifo_signal_oe = 1'b1;
          count_nxt      = count_q - CW'(1);
        end else begin
          flush_done = 1'b1;
          state_nxt  = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      count_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      last_wr <= 1'b0;
    end else begin
      state   <= state_nxt;
      count_q <= count_nxt;
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      last_wr <= last_wr_nxt;
    end
  end

endmodule

// File: tb/tb_pu_fifo_sched.sv
// Testbench for pu_fifo_sched: a queue-based scheduler model is checked
// against the DUT on every falling edge, and directed literal checks pin
// the model at key points. A simple FIFO model sits behind the DUT.
module tb_pu_fifo_sched;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int FS = 3;
  localparam int N  = 2;
  localparam int CW = $clog2(FS + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    wr_req = '0;
  logic [N*DW-1:0] wr_data = '0;
  logic [N*AW-1:0] wr_attr = '0;
  logic [N-1:0]    rd_req = '0;
  logic            flush = 1'b0;
  logic [N-1:0]    wr_grant, rd_grant;
  logic [DW-1:0]   rd_data, fifo_data_in, fifo_data_out;
  logic [AW-1:0]   rd_attr, fifo_attr_in, fifo_attr_out;
  logic            flush_done, full, empty, fifo_signal_wr, fifo_signal_oe;
  logic [CW-1:0]   count;

  pu_fifo_sched #(.DATA_WIDTH(DW), .ATTR_WIDTH(AW), .FIFO_SIZE(FS), .N_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_data(wr_data), .wr_attr(wr_attr), .wr_grant(wr_grant),
    .rd_req(rd_req), .rd_grant(rd_grant), .rd_data(rd_data), .rd_attr(rd_attr),
    .flush(flush), .flush_done(flush_done),
    .count(count), .full(full), .empty(empty),
    .fifo_data_in(fifo_data_in), .fifo_attr_in(fifo_attr_in),
    .fifo_signal_wr(fifo_signal_wr), .fifo_signal_oe(fifo_signal_oe),
    .fifo_data_out(fifo_data_out), .fifo_attr_out(fifo_attr_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO unit behind the scheduler, combinational head read-out.
  logic [DW-1:0] bf_d [0:7];
  logic [AW-1:0] bf_a [0:7];
  int bf_n = 0;
  assign fifo_data_out = (bf_n > 0) ? bf_d[0] : '0;
  assign fifo_attr_out = (bf_n > 0) ? bf_a[0] : '0;

  always @(posedge clk) begin
    if (rst) begin
      bf_n <= 0;
    end else if (fifo_signal_wr) begin
      if (bf_n < 8) begin
        bf_d[bf_n] <= fifo_data_in;
        bf_a[bf_n] <= fifo_attr_in;
        bf_n <= bf_n + 1;
      end
    end else if (fifo_signal_oe && bf_n > 0) begin
      for (int i = 0; i < 7; i++) begin
        bf_d[i] <= bf_d[i+1];
        bf_a[i] <= bf_a[i+1];
      end
      bf_n <= bf_n - 1;
    end
  end

  // Scheduler model: contents queue, last op, round-robin pointers, flush mode.
  logic [DW-1:0] m_d [$];
  logic [AW-1:0] m_a [$];
  bit m_last_wr = 1'b0;
  bit m_flush = 1'b0;
  int m_wptr = 0;
  int m_rptr = 0;

  always @(negedge clk) begin : cmp
    logic [N-1:0]  e_wg, e_rg;
    logic          e_swr, e_soe, e_done;
    logic [DW-1:0] e_din, e_rd;
    logic [AW-1:0] e_ain, e_ra;
    int n, w, r;
    bit we, re;
    if (chk_en) begin
      e_wg = '0; e_rg = '0; e_swr = 0; e_soe = 0; e_done = 0;
      e_din = '0; e_ain = '0; e_rd = '0; e_ra = '0;
      n = m_d.size();
      w = -1; r = -1;
      if (!m_flush) begin
        we = (wr_req != 0) && (n < FS);
        re = (rd_req != 0) && (n > 0);
        if (we && (!re || !m_last_wr)) begin
          for (int j = 0; j < N; j++)
            if (w < 0 && wr_req[(m_wptr + j) % N]) w = (m_wptr + j) % N;
          e_wg[w] = 1'b1; e_swr = 1'b1;
          e_din = wr_data[w*DW +: DW];
          e_ain = wr_attr[w*AW +: AW];
        end else if (re) begin
          for (int j = 0; j < N; j++)
            if (r < 0 && rd_req[(m_rptr + j) % N]) r = (m_rptr + j) % N;
          e_rg[r] = 1'b1; e_soe = 1'b1;
          e_rd = m_d[0]; e_ra = m_a[0];
        end
      end else begin
        if (n > 0) e_soe = 1'b1;
        else e_done = 1'b1;
      end
      chk("wr_grant", wr_grant, e_wg);
      chk("rd_grant", rd_grant, e_rg);
      chk("fifo_signal_wr", fifo_signal_wr, e_swr);
      chk("fifo_signal_oe", fifo_signal_oe, e_soe);
      chk("fifo_data_in", fifo_data_in, e_din);
      chk("fifo_attr_in", fifo_attr_in, e_ain);
      chk("rd_data", rd_data, e_rd);
      chk("rd_attr", rd_attr, e_ra);
      chk("flush_done", flush_done, e_done);
      chk("count", count, n);
      chk("full", full, n == FS);
      chk("empty", empty, n == 0);
      chk("wr_oe_exclusive", fifo_signal_wr & fifo_signal_oe, 0);
      if (rst) begin
        m_d.delete(); m_a.delete();
        m_last_wr = 0; m_flush = 0; m_wptr = 0; m_rptr = 0;
      end else if (!m_flush) begin
        if (w >= 0) begin
          m_d.push_back(e_din); m_a.push_back(e_ain);
          m_last_wr = 1; m_wptr = (w + 1) % N;
        end else if (r >= 0) begin
          void'(m_d.pop_front()); void'(m_a.pop_front());
          m_last_wr = 0; m_rptr = (r + 1) % N;
        end
        if (flush) m_flush = 1;
      end else begin
        if (n > 0) begin
          void'(m_d.pop_front()); void'(m_a.pop_front());
        end else begin
          m_flush = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0] wg [0:2];

  initial begin
    // Reset
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_wr_grant", wr_grant, 0);
    chk("rst_rd_data", rd_data, 0);
    tick();
    rst = 1'b0;

    // Writer0 fills the FIFO, then a 4th push stalls
    wr_req = 2'b01;
    for (int k = 0; k < 3; k++) begin
      wr_data[31:0] = 32'h11 * (k + 1);
      wr_attr[3:0]  = 4'(k + 1);
      @(negedge clk);
      chk("fill_wr_grant", wr_grant, 2'b01);
      tick();
    end
    wr_data[31:0] = 32'h44;
    @(negedge clk);
    chk("full_count", count, 3);
    chk("full_flag", full, 1);
    chk("full_no_grant", wr_grant, 0);
    chk("full_no_signal_wr", fifo_signal_wr, 0);
    tick();

    // Reader1 drains in order, then a 4th pop stalls
    wr_req = 2'b00;
    rd_req = 2'b10;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("drain_rd_grant", rd_grant, 2'b10);
      chk("drain_rd_data", rd_data, 32'h11 * (k + 1));
      chk("drain_rd_attr", rd_attr, k + 1);
      tick();
    end
    @(negedge clk);
    chk("empty_flag", empty, 1);
    chk("empty_no_grant", rd_grant, 0);
    chk("empty_rd_data", rd_data, 0);
    tick();

    // Both writers contend while reader0 pops every other cycle
    wr_req = 2'b11;
    rd_req = 2'b00;
    for (int c = 0; c < 6; c++) begin
      wr_data = {32'hB0 + 32'(c), 32'hA0 + 32'(c)};
      wr_attr = {4'(c + 8), 4'(c)};
      rd_req = (c % 2 == 1) ? 2'b01 : 2'b00;
      @(negedge clk);
      if (c % 2 == 0) wg[c/2] = wr_grant;
      tick();
    end
    chk("rr_grant0", wg[0], 2'b10);
    chk("rr_grant1", wg[1], 2'b01);
    chk("rr_grant2", wg[2], 2'b10);

    // Reset, reach count=1 with last op a read, then hold both requests
    wr_req = 0; rd_req = 0; rst = 1'b1;
    tick();
    rst = 1'b0;
    wr_req = 2'b01;
    wr_data[31:0] = 32'hC1; wr_attr[3:0] = 4'h5;
    tick();
    wr_data[31:0] = 32'hC2; wr_attr[3:0] = 4'h6;
    tick();
    wr_req = 2'b00; rd_req = 2'b01;
    tick();
    wr_req = 2'b01;
    for (int i = 0; i < 4; i++) begin
      wr_data[31:0] = 32'hD0 + 32'(i);
      @(negedge clk);
      if (i % 2 == 0) begin
        chk("alt_wr_grant", wr_grant, 2'b01);
        chk("alt_count_lo", count, 1);
      end else begin
        chk("alt_rd_grant", rd_grant, 2'b01);
        chk("alt_count_hi", count, 2);
      end
      tick();
    end

    // Fill to 3, flush, writer held through the drain
    rd_req = 2'b00;
    wr_data[31:0] = 32'hE1;
    tick();
    wr_data[31:0] = 32'hE2;
    tick();
    wr_req = 2'b00; flush = 1'b1;
    @(negedge clk);
    chk("flush_entry_count", count, 3);
    tick();
    flush = 1'b0; wr_req = 2'b01;
    for (int i = 0; i < 3; i++) begin
      flush = (i == 1);
      @(negedge clk);
      chk("flush_oe", fifo_signal_oe, 1);
      chk("flush_no_grant", wr_grant, 0);
      chk("flush_count", count, 3 - i);
      tick();
    end
    flush = 1'b0;
    @(negedge clk);
    chk("flush_done_pulse", flush_done, 1);
    chk("flush_done_no_oe", fifo_signal_oe, 0);
    tick();
    @(negedge clk);
    chk("post_flush_count", count, 0);
    chk("post_flush_grant", wr_grant, 2'b01);
    chk("post_flush_done_low", flush_done, 0);
    tick();

    // Flush from empty completes in the first FLUSH cycle
    wr_req = 2'b00; rd_req = 2'b01;
    tick();
    rd_req = 2'b00; flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("flush0_done", flush_done, 1);
    chk("flush0_no_oe", fifo_signal_oe, 0);
    tick();

    // Reset while flushing with count=2
    wr_req = 2'b01;
    wr_data[31:0] = 32'hF1;
    tick();
    wr_data[31:0] = 32'hF2;
    tick();
    wr_req = 2'b00; flush = 1'b1;
    tick();
    flush = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rstflush_pre_oe", fifo_signal_oe, 1);
    chk("rstflush_pre_count", count, 2);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rstflush_count", count, 0);
    chk("rstflush_empty", empty, 1);
    chk("rstflush_no_oe", fifo_signal_oe, 0);
    chk("rstflush_no_done", flush_done, 0);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
